// File: rtl/walksat_core.sv
`default_nettype none
// ============================================================================
// walksat_core : WalkSAT-style 3-SAT local-search engine with command port
// Rev 1.0
// ============================================================================
module walksat_core #(
    parameter int NVARS     = 128,
    parameter int NCLAUSES  = 64,
    parameter int FW        = 16,
    parameter int MAX_FLIPS = 1000,
    parameter int LW        = $clog2(NVARS) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    cmd_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [LW-1:0] bus_a_i,
    input  logic [LW-1:0] bus_b_i,
    input  logic [LW-1:0] bus_c_i,
    output logic          sat_o,
    output logic          unsat_o,
    output logic          busy_o,
    output logic          ovf_o,
    output logic [7:0]    exbus_o,
    output logic          exbus_valid_o,
    output logic [FW-1:0] flip_count_o
);
    localparam int IW     = LW - 1;
    localparam int CW     = $clog2(NCLAUSES + 1);
    localparam int AW     = (NCLAUSES > 1) ? $clog2(NCLAUSES) : 1;
    localparam int NBEATS = NVARS / 8;
    localparam int BW     = $clog2(NBEATS + 1);

    localparam logic [CW-1:0] C_NCLAUSES  = CW'(NCLAUSES);
    localparam logic [FW-1:0] C_MAX_FLIPS = FW'(MAX_FLIPS);
    localparam logic [BW-1:0] C_NBEATS    = BW'(NBEATS);
    localparam logic [15:0]   C_LFSR_INIT = 16'hACE1;
    localparam logic [15:0]   C_LFSR_TAPS = 16'hB400;

    localparam logic [2:0] C_CMD_RST_MODEL = 3'd0;
    localparam logic [2:0] C_CMD_RST_STATE = 3'd1;
    localparam logic [2:0] C_CMD_INS       = 3'd2;
    localparam logic [2:0] C_CMD_GET       = 3'd3;
    localparam logic [2:0] C_CMD_WALK      = 3'd4;
    localparam logic [2:0] C_CMD_SEED      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_EVAL = 3'd2,
        S_FLIP = 3'd3,
        S_DONE = 3'd4,
        S_GET  = 3'd5
    } state_t;

    state_t          state_q;
    logic            cmd_ready_q;
    logic            sat_q;
    logic            unsat_q;
    logic            busy_q;
    logic            ovf_q;
    logic [7:0]      exbus_q;
    logic            exbus_valid_q;
    logic [FW-1:0]   flip_count_q;
    logic [CW-1:0]   count_q;
    logic [NVARS-1:0] asg_q;
    logic [15:0]     lfsr_q;
    logic [AW-1:0]   scan_q;
    logic [AW-1:0]   clause_q;
    logic            found_q;
    logic [BW-1:0]   beat_q;

    logic [3*LW-1:0] mem_q [NCLAUSES];

    logic            w_accept;
    logic            w_ins_wr;
    logic [3*LW-1:0] w_scan_clause;
    logic            w_scan_unsat;
    logic [AW-1:0]   w_last;
    logic [IW-1:0]   w_flip_idx;
    logic            w_flip_ok;
    logic [15:0]     lfsr_d;
    logic [15:0]     w_seed;
    logic [7:0]      w_byte;

    // Indices past NVARS read as constant false regardless of the negation bit.
    function automatic logic lit_true(input logic [NVARS-1:0] asg, input logic [LW-1:0] lit);
        logic [31:0] idx32;
        idx32    = 32'(lit[IW-1:0]);
        lit_true = (idx32 < 32'(NVARS)) ? (asg[lit[IW-1:0]] ^ lit[LW-1]) : 1'b0;
    endfunction

    assign w_accept      = cmd_valid_i && cmd_ready_q;
    assign w_ins_wr      = w_accept && (cmd_i == C_CMD_INS) && (count_q != C_NCLAUSES);
    assign w_scan_clause = mem_q[scan_q];
    assign w_scan_unsat  = !(lit_true(asg_q, w_scan_clause[3*LW-1 -: LW]) ||
                             lit_true(asg_q, w_scan_clause[2*LW-1 -: LW]) ||
                             lit_true(asg_q, w_scan_clause[LW-1 -: LW]));
    assign w_last        = AW'(count_q - CW'(1));
    assign lfsr_d        = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? C_LFSR_TAPS : 16'h0000);
    assign w_seed        = 16'({bus_a_i, bus_b_i});
    assign w_byte        = 8'(asg_q >> {beat_q, 3'b000});
    assign w_flip_ok     = 32'(w_flip_idx) < 32'(NVARS);

    // LFSR value 3 falls back to the first literal.
    always_comb begin
        w_flip_idx = mem_q[clause_q][3*LW-2 -: IW];
        case (lfsr_q[1:0])
            2'd1:    w_flip_idx = mem_q[clause_q][2*LW-2 -: IW];
            2'd2:    w_flip_idx = mem_q[clause_q][LW-2 -: IW];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_ins_wr) begin
            mem_q[count_q[AW-1:0]] <= {bus_a_i, bus_b_i, bus_c_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b1;
            sat_q         <= 1'b0;
            unsat_q       <= 1'b0;
            busy_q        <= 1'b0;
            ovf_q         <= 1'b0;
            exbus_q       <= 8'h00;
            exbus_valid_q <= 1'b0;
            flip_count_q  <= '0;
            count_q       <= '0;
            asg_q         <= '0;
            lfsr_q        <= C_LFSR_INIT;
            scan_q        <= '0;
            clause_q      <= '0;
            found_q       <= 1'b0;
            beat_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        case (cmd_i)
                            C_CMD_RST_MODEL: begin
                                count_q <= '0;
                                ovf_q   <= 1'b0;
                                sat_q   <= 1'b0;
                                unsat_q <= 1'b0;
                            end
                            C_CMD_RST_STATE: begin
                                asg_q        <= '0;
                                flip_count_q <= '0;
                                sat_q        <= 1'b0;
                                unsat_q      <= 1'b0;
                            end
                            C_CMD_INS: begin
                                if (count_q == C_NCLAUSES) ovf_q <= 1'b1;
                                else                       count_q <= count_q + CW'(1);
                            end
                            C_CMD_GET: begin
                                state_q     <= S_GET;
                                beat_q      <= '0;
                                busy_q      <= 1'b1;
                                cmd_ready_q <= 1'b0;
                            end
                            C_CMD_WALK: begin
                                sat_q        <= 1'b0;
                                unsat_q      <= 1'b0;
                                flip_count_q <= '0;
                                busy_q       <= 1'b1;
                                cmd_ready_q  <= 1'b0;
                                scan_q       <= '0;
                                found_q      <= 1'b0;
                                state_q      <= (count_q == '0) ? S_EVAL : S_SCAN;
                            end
                            C_CMD_SEED: begin
                                lfsr_q <= (w_seed == 16'h0000) ? C_LFSR_INIT : w_seed;
                            end
                            default: ;
                        endcase
                    end
                end
                S_SCAN: begin
                    if (w_scan_unsat && !found_q) begin
                        found_q  <= 1'b1;
                        clause_q <= scan_q;
                    end
                    if (scan_q == w_last) state_q <= S_EVAL;
                    else                  scan_q  <= scan_q + AW'(1);
                end
                S_EVAL: begin
                    state_q <= (!found_q || flip_count_q == C_MAX_FLIPS) ? S_DONE : S_FLIP;
                end
                S_FLIP: begin
                    if (w_flip_ok) asg_q[w_flip_idx] <= ~asg_q[w_flip_idx];
                    flip_count_q <= flip_count_q + FW'(1);
                    lfsr_q       <= lfsr_d;
                    scan_q       <= '0;
                    found_q      <= 1'b0;
                    state_q      <= S_SCAN;
                end
                S_DONE: begin
                    sat_q       <= !found_q;
                    unsat_q     <= found_q;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_GET: begin
                    if (beat_q == C_NBEATS) begin
                        exbus_q       <= 8'h00;
                        exbus_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        cmd_ready_q   <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        exbus_q       <= w_byte;
                        exbus_valid_q <= 1'b1;
                        beat_q        <= beat_q + BW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign sat_o         = sat_q;
    assign unsat_o       = unsat_q;
    assign busy_o        = busy_q;
    assign ovf_o         = ovf_q;
    assign exbus_o       = exbus_q;
    assign exbus_valid_o = exbus_valid_q;
    assign flip_count_o  = flip_count_q;

endmodule
`default_nettype wire

// File: tb/tb_walksat_core.sv
`default_nettype none
// ============================================================================
// tb_walksat_core : randomized bench for walksat_core against a behavioural model
// Rev 1.0
// ============================================================================
module tb_walksat_core;
    localparam int NV  = 16;
    localparam int NC  = 4;
    localparam int FWT = 8;
    localparam int MF  = 4;
    localparam int LWT = $clog2(NV) + 1;
    localparam int NEG = 1 << (LWT - 1);

    localparam logic [2:0] OP_RST_MODEL = 3'd0;
    localparam logic [2:0] OP_RST_STATE = 3'd1;
    localparam logic [2:0] OP_INS       = 3'd2;
    localparam logic [2:0] OP_GET       = 3'd3;
    localparam logic [2:0] OP_WALK      = 3'd4;
    localparam logic [2:0] OP_SEED      = 3'd5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [2:0]     cmd;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [LWT-1:0] bus_a, bus_b, bus_c;
    logic           sat, unsat, busy, ovf;
    logic [7:0]     exbus;
    logic           exbus_valid;
    logic [FWT-1:0] flip_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          qa[$], qb[$], qc[$];
    logic [NV-1:0] m_asg;
    int          m_lfsr;
    bit          m_ovf;

    always #5 clk = ~clk;

    walksat_core #(
        .NVARS(NV), .NCLAUSES(NC), .FW(FWT), .MAX_FLIPS(MF)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_i(cmd), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .bus_a_i(bus_a), .bus_b_i(bus_b), .bus_c_i(bus_c),
        .sat_o(sat), .unsat_o(unsat), .busy_o(busy), .ovf_o(ovf),
        .exbus_o(exbus), .exbus_valid_o(exbus_valid), .flip_count_o(flip_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit lit_true(input int lit);
        int idx;
        idx = lit % NEG;
        if (idx >= NV) return 1'b0;
        return m_asg[idx] ^ (lit >= NEG);
    endfunction

    task automatic model_reset();
        qa.delete(); qb.delete(); qc.delete();
        m_asg  = '0;
        m_lfsr = 'hACE1;
        m_ovf  = 1'b0;
    endtask

    // Plain WalkSAT loop: first unsatisfied clause, pick a literal from the LFSR, flip.
    task automatic model_walk(output bit w_sat, output int w_flips);
        int bad, k, lit, v;
        bit done;
        w_flips = 0; w_sat = 1'b0; done = 1'b0;
        while (!done) begin
            bad = -1;
            for (int i = 0; i < qa.size(); i++)
                if (bad < 0 && !(lit_true(qa[i]) || lit_true(qb[i]) || lit_true(qc[i]))) bad = i;
            if (bad < 0) begin
                w_sat = 1'b1; done = 1'b1;
            end else if (w_flips == MF) begin
                done = 1'b1;
            end else begin
                k = m_lfsr % 4;
                if (k == 3) k = 0;
                lit = (k == 0) ? qa[bad] : ((k == 1) ? qb[bad] : qc[bad]);
                v = lit % NEG;
                if (v < NV) m_asg[v] = ~m_asg[v];
                w_flips++;
                m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr % 2) == 1) ? 'hB400 : 0);
            end
        end
    endtask

    task automatic send(input logic [2:0] op, input int a, input int b, input int c);
        cmd = op; bus_a = LWT'(a); bus_b = LWT'(b); bus_c = LWT'(c);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_ins(input int a, input int b, input int c);
        send(OP_INS, a, b, c);
        if (qa.size() == NC) m_ovf = 1'b1;
        else begin qa.push_back(a); qb.push_back(b); qc.push_back(c); end
        check_eq("ins_ovf", ovf, m_ovf);
    endtask

    task automatic do_seed(input int a, input int b);
        send(OP_SEED, a, b, 0);
        m_lfsr = ((a << LWT) | b) & 'hFFFF;
        if (m_lfsr == 0) m_lfsr = 'hACE1;
    endtask

    task automatic do_rst_model();
        send(OP_RST_MODEL, 0, 0, 0);
        qa.delete(); qb.delete(); qc.delete();
        m_ovf = 1'b0;
        check_eq("rst_model_ovf", ovf, 0);
        check_eq("rst_model_sat", {sat, unsat}, 0);
    endtask

    task automatic do_rst_state();
        send(OP_RST_STATE, 0, 0, 0);
        m_asg = '0;
        check_eq("rst_state_flips", flip_count, 0);
        check_eq("rst_state_sat", {sat, unsat}, 0);
    endtask

    task automatic do_walk(input string tag);
        bit m_sat;
        int m_flips, n, lat, exp_lat;
        n = qa.size();
        model_walk(m_sat, m_flips);
        exp_lat = 2 + n + m_flips * (n + 2);
        send(OP_WALK, 0, 0, 0);
        check_eq({tag, "_busy"}, {busy, cmd_ready}, 2'b10);
        // A command offered while busy must be dropped, not queued
        cmd = OP_INS; bus_a = LWT'($urandom); bus_b = LWT'($urandom); bus_c = LWT'($urandom);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (busy && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_sat"}, sat, m_sat);
        check_eq({tag, "_unsat"}, unsat, !m_sat);
        check_eq({tag, "_flips"}, flip_count, m_flips);
        check_eq({tag, "_ready"}, cmd_ready, 1);
    endtask

    task automatic do_get(input string tag);
        int beats, cyc;
        send(OP_GET, 0, 0, 0);
        check_eq({tag, "_gap"}, {busy, exbus_valid}, 2'b10);
        beats = 0; cyc = 0;
        while (busy && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (exbus_valid) begin
                check_eq({tag, "_byte"}, exbus, (beats < NV / 8) ? 8'(m_asg >> (8 * beats)) : 8'h00);
                check_eq({tag, "_slot"}, cyc, beats + 1);
                beats++;
            end
        end
        check_eq({tag, "_beats"}, beats, NV / 8);
        check_eq({tag, "_end"}, {cmd_ready, exbus_valid}, 2'b10);
    endtask

    function automatic int rand_lit();
        return int'($urandom_range(0, 2 * NEG - 1));
    endfunction

    initial begin
        cmd = '0; cmd_valid = 1'b0; bus_a = '0; bus_b = '0; bus_c = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("reset_ready", cmd_ready, 1);
        check_eq("reset_flags", {sat, unsat, busy, ovf, exbus_valid}, 0);
        check_eq("reset_flips", flip_count, 0);
        check_eq("reset_exbus", exbus, 0);
        do_get("reset_get");

        // Single satisfiable clause needing one flip
        do_ins(0, 0, 0);
        do_walk("one_flip");
        check_eq("one_flip_cnt", flip_count, 1);
        do_get("one_flip_get");

        // x0 and not-x0 can never both hold: budget runs out
        do_rst_model();
        do_rst_state();
        do_ins(0, 0, 0);
        do_ins(NEG, NEG, NEG);
        do_walk("contra");
        check_eq("contra_unsat", {sat, unsat}, 2'b01);
        check_eq("contra_flips", flip_count, MF);

        do_rst_model();
        do_walk("empty");
        check_eq("empty_sat", sat, 1);

        // Fifth insert overflows a 4-deep memory
        for (int i = 0; i < 5; i++) do_ins(rand_lit(), rand_lit(), rand_lit());
        check_eq("ovf_set", ovf, 1);
        do_walk("ovf_walk");
        do_rst_model();

        do_seed(0, 0);
        do_ins(1, 1, 1);
        do_walk("seed_zero");

        send(3'd6, 0, 0, 0);
        check_eq("noop_ready", {cmd_ready, busy}, 2'b10);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: do_rst_model();
                1: do_rst_state();
                2: do_seed(int'($urandom_range(0, 2 * NEG - 1)), int'($urandom_range(0, 2 * NEG - 1)));
                3: begin
                    send(3'(6 + $urandom_range(0, 1)), rand_lit(), rand_lit(), rand_lit());
                    check_eq("rnd_noop", cmd_ready, 1);
                end
                default: ;
            endcase
            repeat ($urandom_range(0, 3)) do_ins(rand_lit(), rand_lit(), rand_lit());
            do_walk("rnd_walk");
            if (it % 4 == 0) do_get("rnd_get");
        end

        // Reset in the middle of a long walk
        do_rst_model();
        do_rst_state();
        do_ins(0, 0, 0);
        do_ins(NEG, NEG, NEG);
        do_ins(1, 2, 3);
        do_ins(4, 5, 6);
        send(OP_WALK, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_eq("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_flags", {busy, sat, unsat, ovf, exbus_valid}, 0);
        check_eq("mid_ready", cmd_ready, 1);
        check_eq("mid_flips", flip_count, 0);
        model_reset();
        do_get("mid_get");
        do_walk("mid_empty");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
